adder_responder: RTL and testbench

Responder end of the interface adder service: accepts add requests from a caller module over a valid/ready request channel, computes a two's-complement sum with overflow flag, and returns tagged results in request order over a valid/ready response channel. It replaces the zero-time combinational adder call wherever a registered, back-pressurable service is needed between a caller module and the top-level interface instance. Internally it has one compute register stage followed by a DEPTH-entry result FIFO.

---
 rtl/adder_responder.sv | 126 ++++++++++++
 tb/tb_adder_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_responder.sv
// Registered adder service: one compute stage feeding an in-order result FIFO,
// with valid/ready handshakes on both the request and the response side.
module adder_responder #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [WIDTH-1:0]             i_req_a,
  input  logic [WIDTH-1:0]             i_req_b,
  input  logic [TAG_W-1:0]             i_req_tag,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [WIDTH-1:0]             o_rsp_sum,
  output logic                         o_rsp_ovf,
  output logic [TAG_W-1:0]             o_rsp_tag,
  output logic [$clog2(DEPTH+1)-1:0]   o_outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  function automatic logic signed [WIDTH-1:0] wrap_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a + b;
  endfunction

  function automatic logic add_ovf(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] s
  );
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] req_a_s;
  logic signed [WIDTH-1:0] req_b_s;
  logic signed [WIDTH-1:0] sum_next;

  logic                    vld_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic                    ovf_p0;
  logic [TAG_W-1:0]        tag_p0;

  logic signed [WIDTH-1:0] sum_mem [DEPTH];
  logic                    ovf_mem [DEPTH];
  logic [TAG_W-1:0]        tag_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        occ;

  logic accept;
  logic push;
  logic pop;

  assign req_a_s  = $signed(i_req_a);
  assign req_b_s  = $signed(i_req_b);
  assign sum_next = wrap_add(req_a_s, req_b_s);

  // Readiness depends only on registered occupancy, so the stage entry always
  // has a free FIFO slot by the time it is pushed.
  assign occ           = fifo_count + CNT_W'(vld_p0);
  assign o_outstanding = occ;
  assign o_req_ready   = occ < DEPTH_C;
  assign o_rsp_valid   = fifo_count != '0;

  assign accept = i_req_valid && o_req_ready;
  assign push   = vld_p0;
  assign pop    = o_rsp_valid && i_rsp_ready;

  // Head data is masked while empty so outputs read zero after reset without
  // having to clear the storage.
  assign o_rsp_sum = o_rsp_valid ? $unsigned(sum_mem[rd_ptr]) : '0;
  assign o_rsp_ovf = o_rsp_valid ? ovf_mem[rd_ptr] : 1'b0;
  assign o_rsp_tag = o_rsp_valid ? tag_mem[rd_ptr] : '0;

  // ---- stage p0: compute register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      sum_p0 <= sum_next;
      ovf_p0 <= add_ovf(req_a_s, req_b_s, sum_next);
      tag_p0 <= i_req_tag;
    end
  end

  // ---- stage p1: result FIFO ----
  always_ff @(posedge i_clk) begin
    if (push) begin
      sum_mem[wr_ptr] <= sum_p0;
      ovf_mem[wr_ptr] <= ovf_p0;
      tag_mem[wr_ptr] <= tag_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_responder.sv
// Directed bench for adder_responder: vector table plus handshake sequences,
// with an in-order scoreboard checking every response that leaves the DUT.
module tb_adder_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_ovf;
  logic [3:0]  rsp_tag;
  logic [2:0]  outstanding;

  adder_responder #(.WIDTH(32), .TAG_W(4), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_tag(req_tag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_sum(rsp_sum), .o_rsp_ovf(rsp_ovf), .o_rsp_tag(rsp_tag),
    .o_outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] sum;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic last_rf;
  logic last_pf;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: score handshakes seen before the edge, then check hold/occupancy after it.
  task automatic tick();
    logic        stall;
    logic [31:0] h_sum;
    logic        h_ovf;
    logic [3:0]  h_tag;
    logic [31:0] s;
    rsp_t        e;
    last_rf = req_valid && req_ready;
    last_pf = rsp_valid && rsp_ready;
    stall   = rsp_valid && !rsp_ready && !rst;
    h_sum = rsp_sum; h_ovf = rsp_ovf; h_tag = rsp_tag;
    if (!rst) begin
      if (last_pf) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_spurious: got response tag %0d, expected none", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", rsp_sum, e.sum);
          chk("sb_ovf", rsp_ovf, e.ovf);
          chk("sb_tag", rsp_tag, e.tag);
        end
      end
      if (last_rf) begin
        s = req_a + req_b;
        e.sum = s;
        e.ovf = (req_a[31] == req_b[31]) && (s[31] != req_a[31]);
        e.tag = req_tag;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (stall) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_sum", rsp_sum, h_sum);
        chk("hold_ovf", rsp_ovf, h_ovf);
        chk("hold_tag", rsp_tag, h_tag);
      end
      chk("occ_le_depth", outstanding <= 3'd4, 1'b1);
    end
  endtask

  task automatic drain(input string name);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() != 0 || outstanding != 0); k++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  logic rdy_seen[6];
  logic [3:0] tag_order[$];
  int   acc;
  int   sent;
  int   got;
  int   first_c;
  int   last_c;
  int   found;
  int   next_tag;

  initial begin
    vecs[0] = '{32'd5,        32'd7,        4'd3, 32'd12,       1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 4'd1, 32'h80000000, 1'b1};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 4'd2, 32'h7FFFFFFF, 1'b1};
    vecs[3] = '{32'hFFFFFFFD, 32'h00000003, 4'd4, 32'h00000000, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 32'hFFFFFFFE, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 4'd6, 32'h00000000, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b0;

    // Reset values and single request latency
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_rsp_ovf", rsp_ovf, 1'b0);
    chk("rst_rsp_tag", rsp_tag, 4'd0);
    chk("rst_outstanding", outstanding, 3'd0);
    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd7; req_tag = 4'd3; rsp_ready = 1'b1;
    tick();
    chk("single_accepted", last_rf, 1'b1);
    req_valid = 1'b0;
    chk("single_c1_valid", rsp_valid, 1'b0);
    chk("single_c1_outst", outstanding, 3'd1);
    tick();
    chk("single_c2_valid", rsp_valid, 1'b1);
    chk("single_c2_sum", rsp_sum, 32'd12);
    chk("single_c2_ovf", rsp_ovf, 1'b0);
    chk("single_c2_tag", rsp_tag, 4'd3);
    chk("single_c2_outst", outstanding, 3'd1);
    tick();
    chk("single_c3_outst", outstanding, 3'd0);
    chk("single_c3_valid", rsp_valid, 1'b0);

    // Table of arithmetic vectors, one request at a time
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_a = vecs[i].a; req_b = vecs[i].b; req_tag = vecs[i].tag;
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      found = 0;
      for (int k = 0; k < 6; k++) begin
        if (rsp_valid) begin found = 1; break; end
        tick();
      end
      chk("vec_rsp_seen", found, 1);
      chk("vec_sum", rsp_sum, vecs[i].sum);
      chk("vec_ovf", rsp_ovf, vecs[i].ovf);
      chk("vec_tag", rsp_tag, vecs[i].tag);
      tick();
    end
    drain("vec_drain");

    // Back-pressure fill: only DEPTH of six offers get in
    rsp_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 6; t++) begin
      req_valid = 1'b1; req_a = 32'(t * 10); req_b = 32'd1; req_tag = 4'(t);
      rdy_seen[t] = req_ready;
      tick();
      if (last_rf) acc++;
    end
    for (int t = 0; t < 6; t++) chk("bp_ready_pattern", rdy_seen[t], (t < 4) ? 1'b1 : 1'b0);
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", req_ready, 1'b0);
    chk("bp_outstanding", outstanding, 3'd4);
    next_tag = 4;
    req_a = 32'd40; req_tag = 4'd4;
    rsp_ready = 1'b1;
    if (rsp_valid) tag_order.push_back(rsp_tag);
    tick();
    chk("bp_recover_ready", req_ready, 1'b1);
    for (int k = 0; k < 20 && tag_order.size() < 6; k++) begin
      if (next_tag < 6) begin
        req_valid = 1'b1; req_a = 32'(next_tag * 10); req_tag = 4'(next_tag);
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) tag_order.push_back(rsp_tag);
      tick();
      if (last_rf) next_tag++;
    end
    chk("bp_order_count", tag_order.size(), 6);
    for (int i = 0; i < 6 && i < tag_order.size(); i++) chk("bp_order_tag", tag_order[i], 4'(i));
    drain("bp_drain");

    // Streaming at full rate
    sent = 0; got = 0; first_c = -1; last_c = -1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && got < 16; k++) begin
      if (sent < 16) begin
        req_valid = 1'b1;
        req_a = 32'(sent) * 32'h01234567;
        req_b = 32'h70000000 + 32'(sent);
        req_tag = 4'(sent);
        chk("stream_ready", req_ready, 1'b1);
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        got++;
      end
      tick();
      if (last_rf) sent++;
    end
    chk("stream_count", got, 16);
    chk("stream_consecutive", last_c - first_c, 15);
    drain("stream_drain");

    // Random stalls with an always-valid requester
    next_tag = 0;
    req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_tag = 4'd0;
    for (int k = 0; k < 80; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_rf) begin
        next_tag++;
        req_a = $urandom; req_b = $urandom; req_tag = 4'(next_tag);
      end
    end
    chk("rand_progress", next_tag > 20, 1'b1);
    drain("rand_drain");

    // Reset with requests outstanding
    rsp_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      req_valid = 1'b1; req_a = 32'(100 + t); req_b = 32'd5; req_tag = 4'(t);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("mid_pre_outst", outstanding, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_outstanding", outstanding, 3'd0);
    chk("mid_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1; req_tag = 4'd9; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) begin found = 1; break; end
      tick();
    end
    chk("mid_rsp_seen", found, 1);
    chk("mid_first_sum", rsp_sum, 32'd2);
    chk("mid_first_tag", rsp_tag, 4'd9);
    drain("mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
